// File: rtl/adam_aes_decipher_pipelined.sv
`default_nettype none
// =============================================================================
// Module : adam_aes_decipher_pipelined (+ adam_aes_inv_round_module)
// Brief  : Fully pipelined AES-128 decipher, ten inverse rounds, 1 block/cycle.
// Rev    : 1.0
// =============================================================================

module adam_aes_inv_round_module #(
   parameter bit IS_FINAL_ROUND = 1'b0
) (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   output logic [127:0] state_out
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      logic [7:0] bb;
      acc = 8'h00;
      x   = a;
      bb  = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) acc = acc ^ x;
         x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2;
      logic [7:0] a3;
      logic [7:0] a12;
      logic [7:0] a15;
      logic [7:0] a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
      a15  = gf_mul(a12, a3);
      a240 = a15;
      for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
   endfunction

   logic [127:0] w_ark;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int c_col = gi / 4;
         localparam int c_row = gi % 4;
         localparam int c_src = 4 * ((c_col - c_row + 4) % 4) + c_row;
         assign w_ark[127-8*gi -: 8] = inv_sbox(state_in[127-8*c_src -: 8])
                                       ^ round_key[127-8*gi -: 8];
      end

      if (IS_FINAL_ROUND) begin : g_final
         assign state_out = w_ark;
      end else begin : g_mix
         for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_ark[127-32*gi -: 8];
            assign w_a1 = w_ark[119-32*gi -: 8];
            assign w_a2 = w_ark[111-32*gi -: 8];
            assign w_a3 = w_ark[103-32*gi -: 8];
            assign state_out[127-32*gi -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b)
                                             ^ gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
            assign state_out[119-32*gi -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e)
                                             ^ gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
            assign state_out[111-32*gi -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09)
                                             ^ gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
            assign state_out[103-32*gi -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d)
                                             ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
         end
      end
   endgenerate

endmodule

module adam_aes_decipher_pipelined (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] round_keys [0:10],
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         idle
);

   localparam int c_stages = 10;

   logic [127:0]        r_state [0:c_stages-1];
   logic [127:0]        w_next  [0:c_stages-1];
   logic [c_stages-1:0] r_valid;
   logic                w_stall;
   logic                w_accept;

   // A stalled output freezes the whole pipeline; there is no bubble collapse.
   assign w_stall   = r_valid[c_stages-1] & ~out_ready;
   assign in_ready  = ~w_stall;
   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_valid[c_stages-1];
   assign out_block = r_state[c_stages-1];
   assign idle      = ~|r_valid;

   genvar gk;
   generate
      for (gk = 0; gk < c_stages; gk++) begin : g_stage
         if (gk == 0) begin : g_first
            adam_aes_inv_round_module #(.IS_FINAL_ROUND(1'b0)) u_round (
               .state_in  (in_block ^ round_keys[10]),
               .round_key (round_keys[9]),
               .state_out (w_next[gk])
            );
         end else if (gk == c_stages - 1) begin : g_last
            adam_aes_inv_round_module #(.IS_FINAL_ROUND(1'b1)) u_round (
               .state_in  (r_state[gk-1]),
               .round_key (round_keys[0]),
               .state_out (w_next[gk])
            );
         end else begin : g_mid
            adam_aes_inv_round_module #(.IS_FINAL_ROUND(1'b0)) u_round (
               .state_in  (r_state[gk-1]),
               .round_key (round_keys[9-gk]),
               .state_out (w_next[gk])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         for (int k = 0; k < c_stages; k++) r_state[k] <= '0;
      end else begin
         if (flush)         r_valid <= '0;
         else if (!w_stall) r_valid <= {r_valid[c_stages-2:0], w_accept};
         if (!w_stall) begin
            for (int k = 0; k < c_stages; k++) r_state[k] <= w_next[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adam_aes_decipher_pipelined.sv
`default_nettype none
// Random plaintexts are enciphered by a software AES model, pushed through the
// decipher, and the outputs are checked in order against the original plaintexts.
module tb_adam_aes_decipher_pipelined;

   logic         clk = 1'b0;
   logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready, idle;
   logic [127:0] in_block, out_block;
   logic [127:0] rk [0:10];

   int           vectors = 0;
   int           miscompares = 0;
   logic [7:0]   sbox [0:255];
   logic [127:0] exp_q [$];
   int           adv_q [$];
   int           adv = 0;
   logic [127:0] cur_exp;
   logic         accepted;
   logic [127:0] pt;
   int           sent;

   always #5 clk = ~clk;

   adam_aes_decipher_pipelined dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .round_keys (rk),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_block  (out_block),
      .idle       (idle)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, req);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, req);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic void expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] ptxt);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = ptxt ^ rk[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++)
            t[127-8*i -: 8] = sbox[s[127-8*(4*((i/4 + i%4) % 4) + i%4) -: 8]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8];
               a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8];
               a3 = t[103-32*c -: 8];
               s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
         end else begin
            s = t;
         end
         s = s ^ rk[r];
      end
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: check outputs against the queue model, then let the edge happen.
   task automatic tick();
      logic exp_v, exp_stall;
      @(negedge clk);
      exp_v = 1'b0;
      if (exp_q.size() > 0) exp_v = (adv - adv_q[0] == 10);
      exp_stall = exp_v && !out_ready;
      check1("idle", idle, exp_q.size() == 0);
      check1("out_valid", out_valid, exp_v);
      check1("in_ready", in_ready, !exp_stall);
      if (exp_v) check("out_block", out_block, exp_q[0]);
      if (exp_v && out_ready) begin
         void'(exp_q.pop_front());
         void'(adv_q.pop_front());
      end
      accepted = in_valid && !exp_stall;
      if (accepted) begin
         exp_q.push_back(cur_exp);
         adv_q.push_back(adv);
      end
      if (!exp_stall) adv++;
      if (flush) begin
         exp_q.delete();
         adv_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_random();
      pt       = rand128();
      in_block = aes_enc(pt);
      cur_exp  = pt;
   endtask

   initial begin
      build_sbox();
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_block  = '0;
      cur_exp   = '0;
      accepted  = 1'b0;
      for (int r = 0; r <= 10; r++) rk[r] = '0;
      #2;
      check1("rst_out_valid", out_valid, 1'b0);
      check("rst_out_block", out_block, 128'h0);
      check1("rst_idle", idle, 1'b1);
      check1("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // FIPS-197 C.1 known answer
      expand_key(128'h000102030405060708090a0b0c0d0e0f);
      in_valid = 1'b1;
      in_block = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      cur_exp  = 128'h00112233445566778899aabbccddeeff;
      tick();
      in_valid = 1'b0;
      repeat (12) tick();

      // Back-to-back streaming
      expand_key(rand128());
      for (int i = 0; i < 32; i++) begin
         send_random();
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (12) tick();

      // Backpressure: out_ready low for 5 cycles starting at cycle 14
      sent = 0;
      send_random();
      for (int i = 0; i < 40; i++) begin
         out_ready = !(i >= 14 && i < 19);
         in_valid  = (sent < 20);
         tick();
         if (accepted) begin
            sent++;
            send_random();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();

      // Flush with 4 blocks in flight, then a fresh block afterwards
      for (int i = 0; i < 7; i++) begin
         in_valid = (i < 4);
         flush    = (i == 6);
         if (i < 4) send_random();
         tick();
      end
      flush = 1'b0;
      tick();
      send_random();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (12) tick();

      // Asynchronous reset pulse mid-flight
      for (int i = 0; i < 3; i++) begin
         send_random();
         in_valid = 1'b1;
         tick();
      end
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check1("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_block", out_block, 128'h0);
      check1("midrst_idle", idle, 1'b1);
      check1("midrst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      adv_q.delete();
      #1;
      reset_n = 1'b1;
      repeat (15) tick();

      // Round trip under one key with random consumer backpressure
      expand_key(rand128());
      sent = 0;
      send_random();
      for (int i = 0; i < 60; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < 16);
         tick();
         if (accepted) begin
            sent++;
            send_random();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
